// File: rtl/seq_accumulator.sv
// seq_accumulator
//   Multi-operand sequential add/subtract unit with a start/done handshake.
//   One shared adder/subtractor folds NOPS captured operands into an
//   accumulator, one operand per clock, and reports the wrapped result
//   together with a sticky signed-overflow flag.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (aborts a running operation)
//   start   operation request, accepted when the unit is free
//   mode    00/11: sum all; 01: op0-op1-...; 10: op0-op1+op2-op3...
//   ops     packed operands, op[k] = ops[k*WIDTH +: WIDTH]
//   result  final value modulo 2^WIDTH, held until the next completion
//   done    one-cycle completion pulse; result/ovf valid with it
//   busy    high while accumulating
//   ovf     signed overflow seen in any step of the last operation
module seq_accumulator #(
    parameter int WIDTH = 8,
    parameter int NOPS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [NOPS*WIDTH-1:0]   ops,
    output logic [WIDTH-1:0]        result,
    output logic                    done,
    output logic                    busy,
    output logic                    ovf
);

    localparam int IDX_W = (NOPS > 2) ? $clog2(NOPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Signed overflow of one add/subtract step, judged on the sign bits only.
    function automatic logic step_overflow(input logic sign_a, input logic sign_b,
                                           input logic sign_r, input logic sub);
        logic ovf_v;
        if (sub) begin
            ovf_v = (sign_a != sign_b) && (sign_r != sign_a);
        end else begin
            ovf_v = (sign_a == sign_b) && (sign_r != sign_a);
        end
        return ovf_v;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ovf_int_q, ovf_int_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   op_q [NOPS];
    logic [WIDTH-1:0]   op_d [NOPS];
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic               sub_s;
    logic [WIDTH-1:0]   operand_s;
    logic [WIDTH-1:0]   step_s;
    logic               step_ovf_s;
    logic               launch_s;

    // Shared datapath: the sign of this step and its wrapped result/overflow.
    always_comb begin
        case (mode_q)
            2'b01:   sub_s = 1'b1;
            2'b10:   sub_s = idx_q[0];   // odd operand index subtracts
            default: sub_s = 1'b0;
        endcase
        operand_s = op_q[idx_q];
        if (sub_s) begin
            step_s = acc_q - operand_s;
        end else begin
            step_s = acc_q + operand_s;
        end
        step_ovf_s = step_overflow(acc_q[WIDTH-1], operand_s[WIDTH-1],
                                   step_s[WIDTH-1], sub_s);
    end

    // A request is taken in IDLE and also on the edge that leaves DONE, so a
    // back-to-back request starts NOPS edges after the previous one; a start
    // seen while still accumulating is simply dropped.
    always_comb begin
        if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            launch_s = start;
        end else begin
            launch_s = 1'b0;
        end
    end

    // Control FSM next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        ovf_int_d = ovf_int_q;
        mode_d    = mode_q;
        op_d      = op_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            S_ACC: begin
                acc_d     = step_s;
                idx_d     = idx_q + IDX_W'(1);
                ovf_int_d = ovf_int_q | step_ovf_s;
                if (idx_q == LAST_IDX) begin
                    result_d = step_s;
                    ovf_d    = ovf_int_q | step_ovf_s;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            S_IDLE, S_DONE: begin
                if (launch_s) begin
                    // Snapshot operands and mode so later input changes
                    // cannot disturb the running operation.
                    for (int k = 0; k < NOPS; k++) begin
                        op_d[k] = ops[k*WIDTH +: WIDTH];
                    end
                    mode_d    = mode;
                    acc_d     = ops[WIDTH-1:0];
                    idx_d     = IDX_W'(1);
                    ovf_int_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_ACC;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            ovf_int_q <= 1'b0;
            mode_q    <= 2'b00;
            for (int k = 0; k < NOPS; k++) begin
                op_q[k] <= '0;
            end
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            ovf_int_q <= ovf_int_d;
            mode_q    <= mode_d;
            op_q      <= op_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_accumulator.sv
module tb_seq_accumulator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT a: WIDTH=8, NOPS=4
    logic         start_a;
    logic [1:0]   mode_a;
    logic [31:0]  ops_a;
    logic [7:0]   result_a;
    logic         done_a, busy_a, ovf_a;

    // DUT b: WIDTH=16, NOPS=7
    logic         start_b;
    logic [1:0]   mode_b;
    logic [111:0] ops_b;
    logic [15:0]  result_b;
    logic         done_b, busy_b, ovf_b;

    // DUT c: WIDTH=8, NOPS=2
    logic         start_c;
    logic [1:0]   mode_c;
    logic [15:0]  ops_c;
    logic [7:0]   result_c;
    logic         done_c, busy_c, ovf_c;

    seq_accumulator #(.WIDTH(8), .NOPS(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .ops(ops_a),
        .result(result_a), .done(done_a), .busy(busy_a), .ovf(ovf_a));

    seq_accumulator #(.WIDTH(16), .NOPS(7)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .ops(ops_b),
        .result(result_b), .done(done_b), .busy(busy_b), .ovf(ovf_b));

    seq_accumulator #(.WIDTH(8), .NOPS(2)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .mode(mode_c), .ops(ops_c),
        .result(result_c), .done(done_c), .busy(busy_c), .ovf(ovf_c));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] ops;      // {op3, op2, op1, op0}
        logic [7:0]  exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one op on DUT a; report completion latency (edges after E), busy
    // samples and samples with busy and done both high.
    task automatic run_a(input logic [1:0] m, input logic [31:0] o,
                         output int lat, output int busy_cnt, output int both);
        @(negedge clk);
        mode_a  = m;
        ops_a   = o;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        lat = -1; busy_cnt = 0; both = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (busy_a && done_a) both++;
            if (done_a) lat = k;
        end
    endtask

    initial begin
        int lat, bcnt, both, pulses, lat2;

        vecs[0] = '{2'b00, 32'h281E140A, 8'h64, 1'b0}; // 10+20+30+40
        vecs[1] = '{2'b10, 32'h050A1432, 8'h23, 1'b0}; // 50-20+10-5
        vecs[2] = '{2'b01, 32'h0102030A, 8'h04, 1'b0}; // 10-3-2-1
        vecs[3] = '{2'b00, 32'h00006464, 8'hC8, 1'b1}; // 100+100 overflows
        vecs[4] = '{2'b00, 32'h000001FF, 8'h00, 1'b0}; // -1+1 wraps, no ovf
        vecs[5] = '{2'b11, 32'h01020304, 8'h0A, 1'b0}; // mode 11 sums
        vecs[6] = '{2'b01, 32'h00000180, 8'h7F, 1'b1}; // -128-1 overflows
        vecs[7] = '{2'b10, 32'h0405017F, 8'h7F, 1'b1}; // 127-1+5-4
        vecs[8] = '{2'b01, 32'h0080FF7F, 8'h00, 1'b1}; // ovf at step 1 stays sticky

        reset = 1'b1;
        start_a = 1'b0; mode_a = 2'b00; ops_a = '0;
        start_b = 1'b0; mode_b = 2'b00; ops_b = '0;
        start_c = 1'b0; mode_c = 2'b00; ops_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", {24'd0, result_a}, 32'd0);
        chk("reset_done", {31'd0, done_a}, 32'd0);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_ovf", {31'd0, ovf_a}, 32'd0);
        reset = 1'b0;

        // Table-driven vectors on DUT a
        for (int i = 0; i < 9; i++) begin
            run_a(vecs[i].mode, vecs[i].ops, lat, bcnt, both);
            chk($sformatf("vec%0d_latency", i), lat, 32'd3);
            chk($sformatf("vec%0d_result", i), {24'd0, result_a}, {24'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_ovf", i), {31'd0, ovf_a}, {31'd0, vecs[i].exp_ovf});
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd3);
            chk($sformatf("vec%0d_busy_done_overlap", i), both, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, done_a}, 32'd0);
            chk($sformatf("vec%0d_result_held", i), {24'd0, result_a}, {24'd0, vecs[i].exp_res});
        end

        // Inputs changed and start held high during ACC
        @(negedge clk);
        mode_a = 2'b00; ops_a = 32'h281E140A; start_a = 1'b1;
        @(posedge clk);
        #1 ops_a = 32'hFFFFFFFF; mode_a = 2'b01;
        pulses = 0; lat = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_a) begin
                pulses++;
                lat = k;
            end
        end
        chk("held_start_pulses", pulses, 32'd1);
        chk("held_start_latency", lat, 32'd3);
        chk("held_start_result", {24'd0, result_a}, 32'h64);
        @(negedge clk);   // after edge E+4: second op accepted
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        chk("restart_done", {31'd0, done_a}, 32'd0);
        start_a = 1'b0;
        lat2 = -1;
        for (int k = 0; k < 20 && lat2 < 0; k++) begin
            @(negedge clk);
            if (done_a) lat2 = k;
        end
        chk("restart_latency", lat2, 32'd2);
        chk("restart_result", {24'd0, result_a}, 32'h02);   // -1 - (-1) - (-1) - (-1)
        chk("restart_ovf", {31'd0, ovf_a}, 32'd0);

        // Reset mid-operation at edge E+2
        run_a(2'b00, 32'h00006464, lat, bcnt, both);
        chk("pre_reset_ovf", {31'd0, ovf_a}, 32'd1);
        @(negedge clk);
        mode_a = 2'b00; ops_a = 32'h281E140A; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        chk("midop_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_result", {24'd0, result_a}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_done", {31'd0, done_a}, 32'd0);
        chk("abort_ovf", {31'd0, ovf_a}, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_a || busy_a) pulses++;
        end
        chk("abort_quiet", pulses, 32'd0);
        run_a(2'b10, 32'h050A1432, lat, bcnt, both);
        chk("post_abort_latency", lat, 32'd3);
        chk("post_abort_result", {24'd0, result_a}, 32'h23);

        // WIDTH=16, NOPS=7: operands 1..7
        @(negedge clk);
        for (int i = 0; i < 7; i++) ops_b[i*16 +: 16] = 16'(i + 1);
        mode_b = 2'b00; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        lat = -1;
        for (int k = 0; k < 30 && lat < 0; k++) begin
            @(negedge clk);
            if (done_b) lat = k;
        end
        chk("w16_latency", lat, 32'd6);
        chk("w16_result", {16'd0, result_b}, 32'd28);
        chk("w16_ovf", {31'd0, ovf_b}, 32'd0);

        // NOPS=2: 9-4 and alternating 3-7
        @(negedge clk);
        mode_c = 2'b01; ops_c = {8'd4, 8'd9}; start_c = 1'b1;
        @(posedge clk);
        #1 start_c = 1'b0;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (done_c) lat = k;
        end
        chk("n2_latency", lat, 32'd1);
        chk("n2_sub_result", {24'd0, result_c}, 32'd5);
        @(negedge clk);
        @(negedge clk);
        mode_c = 2'b10; ops_c = {8'd7, 8'd3}; start_c = 1'b1;
        @(posedge clk);
        #1 start_c = 1'b0;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (done_c) lat = k;
        end
        chk("n2_alt_latency", lat, 32'd1);
        chk("n2_alt_result", {24'd0, result_c}, 32'hFC);
        chk("n2_alt_ovf", {31'd0, ovf_c}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
